// File: rtl/i281_pkg.sv
// Shared constants, FSM encoding and the nibble-to-ASCII helper for the
// i281 DMEM dump block.
package i281_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_READ     = 4'd1,
    ST_CAPTURE  = 4'd2,
    ST_SEND_HI  = 4'd3,
    ST_SEND_LO  = 4'd4,
    ST_SEND_SEP = 4'd5,
    ST_SEND_CR  = 4'd6,
    ST_SEND_LF  = 4'd7,
    ST_FINISH   = 4'd8
  } dump_state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = ASCII_0 + {4'h0, n};
    else           hex_char = ASCII_A + {4'h0, n - 4'd10};
  endfunction

endpackage

// File: rtl/i281_uart_tx.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks.
module i281_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       Tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             busy_q;
  logic             tx_q;

  // Handshake: tx_start is taken only when tx_busy=0; tx_busy rises on the
  // accepting edge. tx_done is high during the final stop-bit cycle, so a
  // caller that starts the next byte on the following cycle leaves exactly
  // one idle-high cycle between frames.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else if (!busy_q) begin
      if (tx_start) begin
        busy_q   <= 1'b1;
        tx_q     <= 1'b0;
        shreg    <= tx_byte;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == LAST_TICK) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy_q  <= 1'b0;
        tx_q    <= 1'b1;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd8) begin
          tx_q <= 1'b1;
        end else begin
          tx_q  <= shreg[0];
          shreg <= shreg >> 1;
        end
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tx_busy = busy_q;
  assign tx_done = busy_q && (bit_cnt == 4'd9) && (baud_cnt == LAST_TICK);
  assign Tx      = tx_q;

endmodule

// File: rtl/i281_dmem_dump_uart.sv
// Reads every DMEM word on request and streams it as "HH " text followed by
// CR LF over a UART transmitter.
module i281_dmem_dump_uart
  import i281_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DMEM_DEPTH   = 16,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Dump_Start,
  output logic              Dmem_Rd_En,
  output logic [ADDR_W-1:0] Dmem_Addr,
  input  logic [DATA_W-1:0] Dmem_Data,
  output logic              Tx,
  output logic              Busy,
  output logic              Done,
  output logic [3:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DMEM_DEPTH - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        word_q;
  logic              addr_clr, addr_inc, word_ld;
  logic              tx_start, tx_busy, tx_done;
  logic [7:0]        tx_byte;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (addr_clr)      addr_q <= '0;
      else if (addr_inc) addr_q <= addr_q + 1'b1;
      if (word_ld) word_q <= Dmem_Data;
    end
  end

  // Send states offer their byte whenever the UART is free; since tx_done
  // coincides with tx_busy=1, each send state launches exactly one frame.
  always_comb begin
    state_d  = state_q;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    word_ld  = 1'b0;
    tx_start = 1'b0;
    tx_byte  = ASCII_SPACE;
    case (state_q)
      ST_IDLE: begin
        if (Dump_Start) begin
          addr_clr = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        word_ld = 1'b1;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        tx_byte  = hex_char(word_q[7:4]);
        tx_start = !tx_busy;
        if (tx_done) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        tx_byte  = hex_char(word_q[3:0]);
        tx_start = !tx_busy;
        if (tx_done) state_d = ST_SEND_SEP;
      end
      ST_SEND_SEP: begin
        tx_byte  = ASCII_SPACE;
        tx_start = !tx_busy;
        if (tx_done) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_SEND_CR;
          end else begin
            addr_inc = 1'b1;
            state_d  = ST_READ;
          end
        end
      end
      ST_SEND_CR: begin
        tx_byte  = ASCII_CR;
        tx_start = !tx_busy;
        if (tx_done) state_d = ST_SEND_LF;
      end
      ST_SEND_LF: begin
        tx_byte  = ASCII_LF;
        tx_start = !tx_busy;
        if (tx_done) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  i281_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .Clock   (Clock),
    .Reset   (Reset),
    .tx_start(tx_start),
    .tx_byte (tx_byte),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .Tx      (Tx)
  );

  assign Dmem_Rd_En = (state_q == ST_READ);
  assign Dmem_Addr  = addr_q;
  assign Busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign Done       = (state_q == ST_FINISH);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i281_dmem_dump_uart.sv
// Bench for i281_dmem_dump_uart: DMEM model, UART decoder feeding a
// scoreboard, read-strobe and Done monitors, directed dump scenarios.
module tb_i281_dmem_dump_uart;

  localparam int CPB       = 4;
  localparam int DEPTH     = 16;
  localparam int DUMP_SPAN = 2079;

  // clock / reset / DUT
  logic       Clock;
  logic       Reset;
  logic       Dump_Start;
  logic       Dmem_Rd_En;
  logic [3:0] Dmem_Addr;
  logic [7:0] rd_data;
  logic       Tx;
  logic       Busy;
  logic       Done;
  logic [3:0] dbg_state;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  i281_dmem_dump_uart #(
    .CLKS_PER_BIT(CPB),
    .DMEM_DEPTH  (DEPTH),
    .ADDR_W      (4),
    .DATA_W      (8)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Dump_Start(Dump_Start),
    .Dmem_Rd_En(Dmem_Rd_En),
    .Dmem_Addr (Dmem_Addr),
    .Dmem_Data (rd_data),
    .Tx        (Tx),
    .Busy      (Busy),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  logic [7:0] mem [DEPTH];
  always @(posedge Clock) if (Dmem_Rd_En) rd_data <= mem[Dmem_Addr];

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  logic [39:0] first_frame;
  int          chars_seen = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_rd = 1'b0;
  string       hexd = "0123456789ABCDEF";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_expected();
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back(hexd[mem[a][7:4]]);
      exp_q.push_back(hexd[mem[a][3:0]]);
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART decoder + scoreboard compare; a frame cut by Reset is discarded.
  initial begin
    logic [39:0] fr;
    logic [7:0]  b;
    logic [7:0]  e;
    bit          aborted;
    forever begin
      @(negedge Clock);
      if (!Reset && Tx === 1'b0) begin
        fr      = '0;
        aborted = 0;
        for (int s = 1; s < 40; s++) begin
          @(negedge Clock);
          if (Reset) begin
            aborted = 1;
            break;
          end
          fr[s] = Tx;
        end
        if (!aborted) begin
          for (int k = 0; k < 8; k++) b[k] = fr[4*k+5];
          if (chars_seen == 0) first_frame = fr;
          chk("frame_start_bit", 64'(fr[3:0]), 64'h0);
          chk("frame_stop_bit", 64'(fr[39:36]), 64'hF);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL char_unexpected: got %02h expected none (cycle %0d)", b, cyc);
          end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL char_%0d: got %02h expected %02h", chars_seen, b, e);
            end
          end
          rx_log.push_back(b);
          chars_seen++;
        end
      end
    end
  end

  // read-strobe and Done monitor
  always @(negedge Clock) begin
    if (Dmem_Rd_En === 1'b1) begin
      chk("rd_addr_order", 64'(Dmem_Addr), 64'(rd_cnt));
      chk("rd_single_cycle", 64'(prev_rd), 64'h0);
      rd_cnt++;
    end
    prev_rd = Dmem_Rd_En;
    if (Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 64'(Busy), 64'h0);
    end
  end

  // driver: one full dump, optional extra Dump_Start when extra_at chars seen
  task automatic run_dump(input int extra_at);
    int t0;
    int span;
    bit pulsed;
    int waited;
    rd_cnt      = 0;
    done_cnt    = 0;
    chars_seen  = 0;
    first_frame = '0;
    rx_log.delete();
    push_expected();
    @(negedge Clock);
    Dump_Start = 1'b1;
    @(negedge Clock);
    Dump_Start = 1'b0;
    t0     = -1;
    pulsed = 0;
    waited = 0;
    while (done_cnt == 0 && waited < 6000) begin
      @(negedge Clock);
      waited++;
      if (t0 < 0 && Tx === 1'b0) begin
        t0 = cyc;
        chk("busy_during_dump", 64'(Busy), 64'h1);
      end
      if (extra_at >= 0 && !pulsed && chars_seen == extra_at) begin
        Dump_Start = 1'b1;
        pulsed     = 1;
      end else begin
        Dump_Start = 1'b0;
      end
    end
    Dump_Start = 1'b0;
    chk("done_timeout", 64'(waited >= 6000), 64'h0);
    span = (done_cnt > 0 && t0 >= 0) ? done_cyc - t0 : -1;
    chk("dump_span", 64'(span), 64'(DUMP_SPAN));
    repeat (60) @(negedge Clock);
    chk("done_pulses", 64'(done_cnt), 64'h1);
    chk("rd_pulses", 64'(rd_cnt), 64'd16);
    chk("char_count", 64'(chars_seen), 64'd50);
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    chk("busy_after_done", 64'(Busy), 64'h0);
    chk("tx_idle_after", 64'(Tx), 64'h1);
    exp_q.delete();
  endtask

  initial begin
    int waited;
    Reset      = 1'b1;
    Dump_Start = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;

    // reset held three cycles
    repeat (3) begin
      @(negedge Clock);
      chk("reset_tx", 64'(Tx), 64'h1);
      chk("reset_busy", 64'(Busy), 64'h0);
      chk("reset_done", 64'(Done), 64'h0);
      chk("reset_rd_en", 64'(Dmem_Rd_En), 64'h0);
      chk("reset_addr", 64'(Dmem_Addr), 64'h0);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // full dump 00,11,...,FF plus first-frame bit timing ('0' = 0x30)
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a * 17);
    run_dump(-1);
    chk("first_frame_bits", 64'(first_frame), 64'hF00FF00000);

    // hex digit boundary 9/A
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    mem[0] = 8'h9A;
    mem[1] = 8'hA9;
    run_dump(-1);
    if (rx_log.size() >= 6) begin
      chk("hex_c0", 64'(rx_log[0]), 64'h39);
      chk("hex_c1", 64'(rx_log[1]), 64'h41);
      chk("hex_c2", 64'(rx_log[2]), 64'h20);
      chk("hex_c3", 64'(rx_log[3]), 64'h41);
      chk("hex_c4", 64'(rx_log[4]), 64'h39);
      chk("hex_c5", 64'(rx_log[5]), 64'h20);
    end else begin
      chk("hex_rx_len", 64'(rx_log.size()), 64'd6);
    end

    // Dump_Start during Busy is dropped
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(8'hF0 - 8'(a * 3));
    run_dump(10);

    // reset in a data bit of character 5
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a * 17);
    rd_cnt     = 0;
    done_cnt   = 0;
    chars_seen = 0;
    push_expected();
    @(negedge Clock);
    Dump_Start = 1'b1;
    @(negedge Clock);
    Dump_Start = 1'b0;
    waited = 0;
    while (chars_seen < 5 && waited < 3000) begin
      @(negedge Clock);
      waited++;
    end
    chk("reach_char5_timeout", 64'(waited >= 3000), 64'h0);
    waited = 0;
    while (Tx !== 1'b0 && waited < 200) begin
      @(negedge Clock);
      waited++;
    end
    chk("char5_start_timeout", 64'(waited >= 200), 64'h0);
    repeat (6) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_tx_high", 64'(Tx), 64'h1);
    chk("abort_busy_low", 64'(Busy), 64'h0);
    @(negedge Clock);
    Reset = 1'b0;
    exp_q.delete();
    repeat (200) @(negedge Clock);
    chk("abort_no_done", 64'(done_cnt), 64'h0);
    chk("abort_tx_idle", 64'(Tx), 64'h1);
    chk("abort_busy_idle", 64'(Busy), 64'h0);

    // fresh dump after the abort
    for (int a = 0; a < DEPTH; a++) mem[a] = {a[3:0], ~a[3:0]};
    run_dump(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
